// File: rtl/cqf_slot_gen.sv
// CQF slot generator: rotates SLOT_NUM slots of (active+1) cycles and emits the slot id, flag, start/wrap pulses, guard window and slot count.
// Latency: first start pulse one cycle after enable; out_guard is combinational from registers and in_guard; no backpressure.
module cqf_slot_gen #(
    parameter int                SLOT_NUM       = 2,
    parameter int                SLOT_ID_W      = 3,
    parameter int                CNT_W          = 32,
    parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = CNT_W'(32'h7a12)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_enable,
    input  logic [CNT_W-1:0]     in_period,
    input  logic                 in_period_wr,
    input  logic [CNT_W-1:0]     in_guard,
    input  logic                 in_sync,
    output logic [SLOT_ID_W-1:0] out_slot_id,
    output logic                 out_slot_flag,
    output logic                 out_slot_start,
    output logic                 out_slot_wrap,
    output logic                 out_guard,
    output logic [31:0]          out_slot_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [SLOT_ID_W-1:0] LAST_ID = SLOT_ID_W'(SLOT_NUM - 1);

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SLOT_ID_W-1:0] slot_id_q, slot_id_d;
    logic                 flag_q, flag_d;
    logic                 start_q, start_d;
    logic                 wrap_q, wrap_d;
    logic [31:0]          slot_cnt_q, slot_cnt_d;
    logic [CNT_W-1:0]     active_q, active_d;
    logic [CNT_W-1:0]     shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 apply;
    logic [CNT_W:0]       guard_sum;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_id_d  = slot_id_q;
        flag_d     = flag_q;
        start_d    = 1'b0;
        wrap_d     = 1'b0;
        slot_cnt_d = slot_cnt_q;
        active_d   = active_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        apply      = 1'b0;

        if (state_q == ST_IDLE) begin
            cnt_d     = '0;
            slot_id_d = '0;
            flag_d    = 1'b0;
            if (in_enable) begin
                state_d    = ST_RUN;
                start_d    = 1'b1;
                slot_cnt_d = slot_cnt_q + 32'd1;
                apply      = 1'b1;
            end
        end else if (!in_enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            slot_id_d = '0;
            flag_d    = 1'b0;
        end else if (in_sync) begin
            cnt_d      = '0;
            slot_id_d  = '0;
            flag_d     = 1'b0;
            start_d    = 1'b1;
            slot_cnt_d = slot_cnt_q + 32'd1;
            apply      = 1'b1;
        end else if (cnt_q == active_q) begin
            cnt_d      = '0;
            slot_id_d  = (slot_id_q == LAST_ID) ? '0 : slot_id_q + SLOT_ID_W'(1);
            wrap_d     = (slot_id_q == LAST_ID);
            flag_d     = ~flag_q;
            start_d    = 1'b1;
            slot_cnt_d = slot_cnt_q + 32'd1;
            apply      = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // The shadow applied here is the pre-edge value, so a write on the
        // same edge stays pending until the next boundary.
        if (apply && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (in_period_wr) begin
            shadow_d  = (in_period == '0) ? CNT_W'(1) : in_period;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            slot_id_q  <= '0;
            flag_q     <= 1'b0;
            start_q    <= 1'b0;
            wrap_q     <= 1'b0;
            slot_cnt_q <= '0;
            active_q   <= DEFAULT_PERIOD;
            shadow_q   <= DEFAULT_PERIOD;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_id_q  <= slot_id_d;
            flag_q     <= flag_d;
            start_q    <= start_d;
            wrap_q     <= wrap_d;
            slot_cnt_q <= slot_cnt_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
        end
    end

    // One extra bit so a huge in_guard cannot wrap the comparison.
    assign guard_sum = {1'b0, cnt_q} + {1'b0, in_guard};

    assign out_slot_id    = slot_id_q;
    assign out_slot_flag  = flag_q;
    assign out_slot_start = start_q;
    assign out_slot_wrap  = wrap_q;
    assign out_slot_cnt   = slot_cnt_q;
    assign out_guard      = (state_q == ST_RUN) && (guard_sum > {1'b0, active_q});

endmodule
